// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-addressable memory.
// One transaction in flight; sequences read latency / write done and returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [1:0]  p0_wsize,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [1:0]  p1_wsize,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_error,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RELEASE} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_write_q, mem_write_d;
  logic        p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  always_comb begin
    logic        gnt;
    logic        fin;
    logic        fin_err;
    logic [1:0]  g_wsize;
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    lat_cnt_d     = lat_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_write_d   = mem_write_q;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    p0_err_d      = p0_err_q;
    p1_err_d      = p1_err_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    gnt           = 1'b0;
    fin           = 1'b0;
    fin_err       = 1'b0;
    g_wsize       = 2'd0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // Tie goes to the port that did not win last time.
          gnt           = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          g_wsize       = gnt ? p1_wsize : p0_wsize;
          owner_d       = gnt;
          last_grant_d  = gnt;
          mem_address_d = gnt ? p1_addr : p0_addr;
          mem_wdata_d   = gnt ? p1_wdata : p0_wdata;
          lat_cnt_d     = 3'(READ_LATENCY);
          if (gnt) p1_err_d = 1'b0;
          else     p0_err_d = 1'b0;
          if (g_wsize == 2'd0) begin
            state_d = RD_WAIT;
          end else begin
            mem_write_d = g_wsize;
            tmo_cnt_d   = 8'(WRITE_TIMEOUT);
            state_d     = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == 3'd1) begin
          fin     = 1'b1;
          fin_err = mem_error;
          if (owner_q) p1_rdata_d = mem_rdata;
          else         p0_rdata_d = mem_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      WR_WAIT: begin
        if (mem_done) begin
          fin     = 1'b1;
          fin_err = mem_error;
        end else if (tmo_cnt_q == 8'd1) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 8'd1;
        end
        if (fin) mem_write_d = 2'd0;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = RELEASE;
      if (owner_q) begin
        p1_ack_d = 1'b1;
        p1_err_d = fin_err;
      end else begin
        p0_ack_d = 1'b1;
        p0_err_d = fin_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      lat_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_write_q   <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_err_q      <= 1'b0;
      p1_err_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      lat_cnt_q     <= lat_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_write_q   <= mem_write_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_err_q      <= p0_err_d;
      p1_err_q      <= p1_err_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_err      = p0_err_q;
  assign p1_err      = p1_err_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_write   = mem_write_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases then random two-port traffic,
// with a memory stub and a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int RL  = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [1:0]  wsize [2];
  logic [31:0] wdata [2];
  logic        p0_ack, p1_ack, p0_err, p1_err, busy, owner, mem_done, mem_error;
  logic [31:0] p0_rdata, p1_rdata, mem_address, mem_wdata, mem_rdata;
  logic [1:0]  mem_write;

  mem_port_arbiter #(.READ_LATENCY(RL), .WRITE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_wsize(wsize[0]), .p0_wdata(wdata[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_wsize(wsize[1]), .p1_wdata(wdata[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // ---------------- memory stub ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd2) return a[0];
    if (sz == 2'd3) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  // Cycles from mem_write rising to mem_done; 0 means the memory never completes.
  function automatic int done_delay(input logic [31:0] wd);
    return int'(wd[2:0] ^ 3'd3);
  endfunction

  logic [31:0] rd_r;
  logic        rd_err_r;
  int          wcnt = 0;

  // One register stage: data is sampled by the arbiter two edges after the address moves.
  always @(posedge clk) begin
    rd_r     <= mem_fn(mem_address);
    rd_err_r <= mem_address[0];
    wcnt     <= (mem_write == 2'd0) ? 0 : wcnt + 1;
  end

  assign mem_rdata = rd_r;
  assign mem_error = (mem_write != 2'd0) ? misaligned(mem_address, mem_write) : rd_err_r;
  assign mem_done  = (mem_write != 2'd0) && (done_delay(mem_wdata) != 0) &&
                     (wcnt == done_delay(mem_wdata) - 1);

  // ---------------- checking infrastructure ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  resp_t       exp0[$];
  resp_t       exp1[$];
  logic [31:0] last_rd [2];
  int          ack_order[$];
  longint      ack_time[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the response a port should see, derived from the memory rules.
  task automatic predict(input int p, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    resp_t r;
    int    d;
    if (sz == 2'd0) begin
      r.rdata    = mem_fn(a);
      r.err      = a[0];
      last_rd[p] = r.rdata;
    end else begin
      d       = done_delay(wd);
      r.rdata = last_rd[p];
      r.err   = (d != 0 && d <= TMO) ? misaligned(a, sz) : 1'b1;
    end
    if (p == 0) exp0.push_back(r);
    else        exp1.push_back(r);
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  task automatic do_txn(input int p, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, output int lat);
    predict(p, a, sz, wd);
    addr[p]  = a;
    wsize[p] = sz;
    wdata[p] = wd;
    req[p]   = 1'b1;
    lat      = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ack_of(p)) break;
      if (lat > 200) begin
        check($sformatf("ack_timeout_p%0d", p), 32'(lat), 32'd0);
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic mon(input int p, input logic [31:0] rd, input logic er);
    resp_t e;
    if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
      check($sformatf("unexpected_ack_p%0d", p), 32'd1, 32'd0);
    end else begin
      e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
      check($sformatf("rdata_p%0d", p), rd, e.rdata);
      check($sformatf("err_p%0d", p), 32'(er), 32'(e.err));
      check($sformatf("owner_p%0d", p), 32'(owner), 32'(p));
    end
    ack_order.push_back(p);
    ack_time.push_back($time);
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst && (p0_ack || p1_ack)) begin
      check("single_ack", 32'(p0_ack & p1_ack), 32'd0);
      if (p0_ack) mon(0, p0_rdata, p0_err);
      if (p1_ack) mon(1, p1_rdata, p1_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; wsize[i] = '0; wdata[i] = '0; last_rd[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p0_ack", 32'(p0_ack), 0);
    check("rst_p1_ack", 32'(p1_ack), 0);
    check("rst_rdata", p0_rdata | p1_rdata, 0);
    check("rst_err", 32'(p0_err | p1_err), 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_busy_owner", 32'({busy, owner}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Read of 0x100 on port 0.
    @(posedge clk); #1;
    fork
      do_txn(0, 32'h100, 2'd0, 32'h0, lat);
      begin
        int nw;
        nw = 0;
        @(posedge clk); #1;
        check("rd_mem_address", mem_address, 32'h100);
        check("rd_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (mem_write != 2'd0) nw++;
        end
        check("rd_mem_write_quiet", 32'(nw), 0);
      end
    join
    check("rd_latency", 32'(lat), 4);

    // Word write on port 1, memory completes after 3 cycles.
    @(posedge clk); #1;
    fork
      do_txn(1, 32'h200, 2'd3, 32'h12345678, lat);
      begin
        int nw;
        nw = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (mem_write == 2'd3) nw++;
          else if (mem_write != 2'd0) nw += 100;
        end
        check("wr_mem_write_cycles", 32'(nw), 3);
      end
    join
    check("wr_latency", 32'(lat), 5);

    // Write that never completes: timeout after TMO cycles, err expected.
    @(posedge clk); #1;
    fork
      do_txn(0, 32'h300, 2'd3, 32'hCAFE0003, lat);
      begin
        int nw;
        nw = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (mem_write == 2'd3) nw++;
        end
        check("tmo_mem_write_cycles", 32'(nw), 32'(TMO));
      end
    join

    // Misaligned accesses raise mem_error.
    @(posedge clk); #1;
    do_txn(0, 32'h101, 2'd0, 32'h0, lat);
    do_txn(1, 32'h101, 2'd2, 32'hABCD0002, lat);

    // Reset in the middle of a write that would otherwise hang.
    @(posedge clk); #1;
    addr[0] = 32'h400; wsize[0] = 2'd3; wdata[0] = 32'h00000003; req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rstmid_write_active", 32'(mem_write), 3);
    rst = 1'b0;
    #1;
    check("rstmid_mem_write", 32'(mem_write), 0);
    check("rstmid_busy", 32'(busy), 0);
    req[0] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Both ports request together from reset: p0 first, then strict alternation.
    ack_order.delete();
    ack_time.delete();
    fork
      begin
        int l0;
        do_txn(0, 32'h10, 2'd0, 32'h0, l0);
        do_txn(0, 32'h14, 2'd0, 32'h0, l0);
      end
      begin
        int l1;
        do_txn(1, 32'h20, 2'd0, 32'h0, l1);
        do_txn(1, 32'h21, 2'd0, 32'h0, l1);
      end
    join
    check("alt_count", 32'(ack_order.size()), 4);
    if (ack_order.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("alt_order_%0d", i), 32'(ack_order[i]), 32'(i % 2));
        if (i > 0) check($sformatf("alt_spacing_%0d", i),
                         32'(ack_time[i] - ack_time[i-1]), 32'((RL + 2) * 10));
      end
    end

    // Random traffic on both ports.
    @(posedge clk); #1;
    fork
      begin
        int l0;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_txn(0, $urandom & 32'h0000_0FFF, 2'($urandom_range(0, 3)), $urandom, l0);
        end
      end
      begin
        int l1;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_txn(1, $urandom & 32'h0000_0FFF, 2'($urandom_range(0, 3)), $urandom, l1);
        end
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("drain_p0", 32'(exp0.size()), 0);
    check("drain_p1", 32'(exp1.size()), 0);
    check("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte_addressable memory between two requesters: port 0 (core fetch/load/store) and port 1 (loader/debug DMA).
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the memory's fixed read latency and its write-completion handshake (done), and returns a one-cycle ack per transaction.
- Sits between the requesters and the memory instance; the core's WAIT_* states are replaced by waiting on ack.

Parameters:
- READ_LATENCY, 2, clock edges from mem_address update to valid mem_rdata (range 1-7).
- WRITE_TIMEOUT, 255, cycles to wait for mem_done before aborting a write with error (range 1-255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_addr  in  32  port 0 byte address.
- p0_wsize  in  2  0 = read, 1 = byte, 2 = half, 3 = word write.
- p0_wdata  in  32  port 0 write data, left-aligned as the memory expects.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  32  read data, valid with ack and held until the next port 0 ack.
- p0_err  out  1  valid with ack: alignment error or write timeout.
- p1_req, p1_addr, p1_wsize, p1_wdata, p1_ack, p1_rdata, p1_err: same as port 0, for port 1.
- mem_address  out  32  to memory address.
- mem_write  out  2  to memory write enable.
- mem_wdata  out  32  to memory d0..d3.
- mem_rdata  in  32  from memory q0..q3.
- mem_done  in  1  memory write complete.
- mem_error  in  1  memory alignment error.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  port currently (or last) granted.

Behaviour:
- Reset (rst = 0, async): state IDLE.
  - All outputs 0: acks, errs, rdata, mem_address, mem_write, mem_wdata, busy, owner.
  - last_grant = 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons it: no ack, and mem_write drops immediately.
- States: IDLE, RD_WAIT, WR_WAIT, RELEASE.
- IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant, register mem_address <= addr, mem_wdata <= wdata, owner and last_grant <= port, and latency count <= READ_LATENCY.
  - wsize = 0: mem_write stays 0, go to RD_WAIT.
  - wsize != 0: mem_write <= wsize, timeout count <= WRITE_TIMEOUT, go to WR_WAIT.
  - No req: stay in IDLE.
- RD_WAIT:
  - Decrement the count each edge.
  - At the edge where the count reaches 1, capture mem_rdata into the owner's rdata and mem_error into the owner's err, and go to RELEASE.
  - Net effect: rdata is sampled exactly READ_LATENCY edges after mem_address changed.
- WR_WAIT:
  - mem_done = 1 on an edge: mem_write <= 0, owner err <= mem_error, go to RELEASE.
  - Otherwise decrement the timeout; on reaching 0: mem_write <= 0, err <= 1, go to RELEASE.
  - mem_done wins over timeout expiry on the same edge.
- RELEASE:
  - The owner's ack is high for exactly this one cycle; all reqs are ignored.
  - Next state is IDLE. This gives the requester one edge to drop req, preventing a duplicate grant.
- Requester obligations:
  - addr, wsize and wdata must stay stable from req rise until ack.
  - Dropping req before ack does not abort the transaction; the ack is still issued.
- Turnaround:
  - Minimum spacing between grants is READ_LATENCY + 2 cycles for reads.
  - With both ports continuously requesting, grants strictly alternate.
- err and rdata are only meaningful while ack is high. rdata holds its value afterwards; err is cleared at the next grant to that port.
- mem_address and mem_wdata hold their last value while IDLE. mem_write is 0 outside WR_WAIT.

Test Plan:
- Reset then p0 read of 0x100 (memory returns 0xDEADBEEF) -> mem_address = 0x100 one edge after req; p0_ack pulses in cycle 4 after req (READ_LATENCY = 2); p0_rdata = 0xDEADBEEF; p0_err = 0; mem_write stays 0.
- p1 word write 0x12345678 to 0x200, mem_done asserted 3 cycles after mem_write rises -> mem_write = 3 for exactly those cycles, then 0; p1_ack one cycle later; p1_err = 0.
- p0 and p1 both raise req together from reset, held continuously, both reads -> grant order p0, p1, p0, p1; never two acks in the same cycle; owner toggles.
- Write with mem_done tied 0, WRITE_TIMEOUT = 4 -> mem_write drops after 4 WR_WAIT cycles; ack with err = 1.
- Half-word read at 0x101 with mem_error = 1 -> ack with err = 1.
- rst pulsed low during WR_WAIT -> mem_write = 0 immediately (async); no ack; after release, p0 wins the next simultaneous request.
